// File: rtl/sum_uart_tx.sv
// sum_uart_tx: buffers 8-bit adder sums in a small FIFO and sends each one
// as an asynchronous serial frame (start, 8 data bits LSB first, stop).
// Optional feature macro SUM_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
//
// Handshake: a sum is transferred on a rising edge where in_valid and
// in_ready are both high; in_valid may stay high while in_ready is low, and
// the producer then holds in_data stable until the transfer happens.
module sum_uart_tx #(
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [7:0]                 in_data,
   output logic                       in_ready,
   output logic                       tx_o,
   output logic                       busy_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef SUM_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          push;
   logic          pop;

   state_t        state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          tx_q, tx_n;
   logic          baud_end;

`ifdef SUM_UART_TX_PARITY_EN
   logic          par_q;
`endif

   assign push     = in_valid && in_ready;
   assign in_ready = (count != LW'(DEPTH));
   assign level_o  = count;
   assign busy_o   = (state != IDLE) || (count != '0);
   assign tx_o     = tx_q;
   assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));

   // FIFO storage: written at the write pointer on every accepted push
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave occupancy as is
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + LW'(1);
         else if (pop && !push) count <= count - LW'(1);
      end
   end

   // Transmitter registers; tx comes straight from a flop so the line is glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         tx_q    <= tx_n;
      end
   end

`ifdef SUM_UART_TX_PARITY_EN
   // Even parity of the byte being loaded, captured when it leaves the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      par_q <= 1'b0;
      else if (pop) par_q <= ^mem[rd_ptr];
   end
`endif

   // Next-state logic; tx_n is the line level for the state being entered
   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      shift_n = shift;
      tx_n    = tx_q;
      pop     = 1'b0;
      if (state != IDLE) begin
         baud_n = baud_end ? '0 : baud + BW'(1);
      end
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (count != '0) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               state_n = START;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (baud_end) begin
               state_n = DATA;
               bit_n   = 3'd0;
               tx_n    = shift[0];
            end
         end
         DATA: begin
            if (baud_end) begin
               if (bit_idx == 3'd7) begin
                  bit_n = 3'd0;
`ifdef SUM_UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = par_q;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_n   = bit_idx + 3'd1;
                  shift_n = {1'b0, shift[7:1]};
                  tx_n    = shift[1];
               end
            end
         end
`ifdef SUM_UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               state_n = STOP;
               tx_n    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_end) begin
               if (count != '0) begin
                  // back-to-back frame: next start bit follows with no idle gap
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule
